// File: rtl/pc_seq_pkg.sv
// Shared types and select encodings for the program-counter sequencer.
// The select encoding matches the external 3:1 next-PC mux inputs d0/d1/d2.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    localparam logic [1:0] SEL_INC = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;

    // Jump outranks a taken branch; taken without branch_en is ignored.
    function automatic logic [1:0] next_sel(input logic jump_en,
                                            input logic branch_en,
                                            input logic taken);
        logic [1:0] sel;
        if (jump_en) begin
            sel = SEL_JMP;
        end else if (branch_en && taken) begin
            sel = SEL_BR;
        end else begin
            sel = SEL_INC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Candidate next-PC arithmetic: increment, relative branch, absolute jump.
// All results are modulo 2^PC_W.
module pc_target_calc #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  jump_addr,
    output logic [PC_W-1:0]  cand_inc,
    output logic [PC_W-1:0]  cand_br,
    output logic [PC_W-1:0]  cand_jmp
);

    logic [PC_W-1:0] off_ext;

    // Sign-extend the two's-complement offset to the PC width.
    assign off_ext  = PC_W'($signed(offset));
    assign cand_inc = pc + PC_W'(1);
    assign cand_br  = pc + off_ext;
    assign cand_jmp = jump_addr;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives the external next-PC mux, registers its
// output as the PC and provides start/halt/stall run control with a cycle counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned OFF_W      = 8,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jump_en,
    input  logic             branch_en,
    input  logic             taken,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  jump_addr,
    output logic [PC_W-1:0]  cand_inc,
    output logic [PC_W-1:0]  cand_br,
    output logic [PC_W-1:0]  cand_jmp,
    output logic [1:0]       pc_sel,
    input  logic [PC_W-1:0]  mux_y,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_inc;

    pc_target_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_target (
        .pc        (pc_q),
        .offset    (offset),
        .jump_addr (jump_addr),
        .cand_inc  (cand_inc),
        .cand_br   (cand_br),
        .cand_jmp  (cand_jmp)
    );

    // Select is only meaningful in RUN; park it on the increment path otherwise.
    assign pc_sel  = (state_q == RUN) ? next_sel(jump_en, branch_en, taken) : SEL_INC;

    // Saturating cycle counter increment.
    assign cnt_inc = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cyc_cnt_d = cyc_cnt_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = START_PC;
                    cyc_cnt_d = '0;
                end
            end
            RUN: begin
                cyc_cnt_d = cnt_inc;
                if (halt_req) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d = mux_y;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            cyc_cnt_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cyc_cnt_q <= cyc_cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;
    assign cyc_cnt = cyc_cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the lab processor datapath.
- Sits directly upstream of the 3:1 next-PC mux: computes the three candidate addresses, drives the mux's d0/d1/d2 and 2-bit select, and registers the mux output as the new PC.
- Adds run control around the fetch address: start, halt, stall and a cycle counter.

Parameters:
PC_W, 8, PC and address width in bits.
OFF_W, 8, width of the signed (two's-complement) branch offset.
START_ADDR, 0, PC value loaded on reset and on every start.
CNT_W, 16, cycle-counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin or restart execution; sampled in IDLE or HALT only.
stall  in  1  hold the PC this cycle (RUN only).
halt_req  in  1  stop execution; highest priority in RUN.
jump_en  in  1  absolute jump this cycle.
branch_en  in  1  conditional branch instruction this cycle.
taken  in  1  branch condition true.
offset  in  OFF_W  signed branch offset, relative to the current PC.
jump_addr  in  PC_W  absolute jump target.
cand_inc  out  PC_W  drives mux d0: pc+1.
cand_br  out  PC_W  drives mux d1: pc+sext(offset).
cand_jmp  out  PC_W  drives mux d2: jump_addr.
pc_sel  out  2  drives mux select s.
mux_y  in  PC_W  mux output, the next PC.
pc  out  PC_W  current PC, registered.
running  out  1  state==RUN.
done  out  1  state==HALT.
cyc_cnt  out  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pc=START_ADDR, cyc_cnt=0, running=0, done=0. pc_sel=00 whenever state!=RUN. Reset asserted mid-RUN aborts immediately, with no final PC update.
- States IDLE, RUN, HALT. running and done are Moore outputs decoded from the registered state.
- IDLE: start=1 moves to RUN next edge and reloads pc=START_ADDR, cyc_cnt=0. start=0 holds all registers.
- RUN, per edge, priority halt_req > stall > update:
  - halt_req=1: move to HALT; pc is not updated this edge; cyc_cnt still increments.
  - stall=1: pc holds; cyc_cnt increments.
  - otherwise: pc <= mux_y; cyc_cnt increments.
  - start is ignored while in RUN.
- cyc_cnt saturates at all-ones; it never wraps.
- pc_sel is combinational, valid only in RUN:
  - jump_en=1 → 2'b10. Jump wins over a simultaneous taken branch.
  - else branch_en&taken → 2'b01.
  - else → 2'b00.
  - pc_sel is never 2'b11. taken with branch_en=0 is ignored.
- Candidate arithmetic is combinational from pc, modulo 2^PC_W:
  - cand_inc = pc+1. 0xFF wraps to 0x00 at PC_W=8.
  - cand_br = pc + sign-extended offset. Wraps in both directions.
  - cand_jmp = jump_addr, unchanged.
- Single-cycle latency: the selected target appears on pc one edge after the control inputs are presented.
- HALT: pc and cyc_cnt frozen, done=1. start=1 returns to RUN with pc=START_ADDR, cyc_cnt=0, done=0 next edge. Control inputs other than start are ignored.
- The block assumes mux_y equals the mux output for the driven pc_sel and candidates. It does not check this.

Decomposition:
- Package pc_seq_pkg:
  - state enum {IDLE, RUN, HALT} (2 bits);
  - select constants SEL_INC=2'b00, SEL_BR=2'b01, SEL_JMP=2'b10.
- One combinational sub-module is natural: pc_target_calc (pc, offset, jump_addr → cand_inc, cand_br, cand_jmp). It carries the sign-extension and wrap logic.
- The 3:1 mux stays external. The bench instantiates it between pc_sequencer's candidate/select outputs and mux_y.

Test Plan:
1. Reset, start pulse, 4 plain cycles (PC_W=8, START_ADDR=0) → pc 0,1,2,3,4; pc_sel=00 throughout; cyc_cnt=4; running=1.
2. Branch at pc=0x10:
   - offset=0xFC, taken=1 → pc_sel=01, next pc=0x0C;
   - repeat with taken=0 → pc_sel=00, next pc=0x11.
3. At pc=0x20, jump_en=1, branch_en=1, taken=1, jump_addr=0x80, offset=0x05 → pc_sel=10, next pc=0x80.
4. Wrap:
   - pc=0xFF plain cycle → pc=0x00;
   - branch at pc=0x02 with offset=0xFC → pc=0xFE;
   - branch at pc=0xF0 with offset=0x7F → pc=0x6F.
5. stall=1 for 2 cycles at pc=0x05, then halt_req=1 together with stall=1 → pc stays 0x05 throughout; HALT entered; done=1, running=0; cyc_cnt frozen. Then start=1 → pc=0x00, cyc_cnt=0, done=0.
6. Reset asserted mid-RUN at pc=0x33, asynchronously between edges:
   - pc=0x00, state IDLE, cyc_cnt=0 immediately, before the next edge;
   - start pulses while reset is held are ignored;
   - with CNT_W=4, 20 RUN cycles → cyc_cnt=0xF, saturated.
